control_resolve_unit: RTL and testbench

//  Consumer at the head of the control-op FIFO (branch/jal/jalr/auipc) in the OoO core.

---
 rtl/control_resolve_if.sv | 69 ++++++
 rtl/control_resolve_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_control_resolve_unit.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_resolve_if.sv
// control_resolve_if
//   Bundles every non-clock/reset signal of control_resolve_unit.
//   master : the resolve unit (reads FIFO head / CDB grant / ROB head,
//            drives dequeue, CDB broadcast, flush and perf counters)
//   slave  : the surrounding core (FIFO, CDB arbiter, ROB, fetch)
//   Groups:
//     ext_flush                        external flush (exception)
//     q_*                              control-op FIFO head and pop
//     cdb_*                            CDB request/grant and payload
//     rob_head_valid / rob_head_idx    ROB commit head
//     flush / redirect_pc              mispredict redirect
//     n_resolved / n_mispred           perf counters
interface control_resolve_if #(
  parameter int ROB_IDX_W = 5,
  parameter int PREG_W    = 6,
  parameter int AREG_W    = 5
);
  logic                 ext_flush;
  // FIFO head
  logic                 q_empty;
  logic                 q_pc_valid;
  logic [1:0]           q_op;
  logic [ROB_IDX_W-1:0] q_rob_idx;
  logic [31:0]          q_pc_in;
  logic [31:0]          q_pc_new;
  logic                 q_br_en;
  logic [31:0]          q_pred_pc;
  logic [AREG_W-1:0]    q_rd;
  logic [PREG_W-1:0]    q_pd;
  logic                 q_dequeue;
  // CDB
  logic                 cdb_req;
  logic                 cdb_gnt;
  logic [ROB_IDX_W-1:0] cdb_rob_idx;
  logic                 cdb_regwrite;
  logic [AREG_W-1:0]    cdb_rd;
  logic [PREG_W-1:0]    cdb_pd;
  logic [31:0]          cdb_data;
  // ROB head
  logic                 rob_head_valid;
  logic [ROB_IDX_W-1:0] rob_head_idx;
  // redirect and perf
  logic                 flush;
  logic [31:0]          redirect_pc;
  logic [31:0]          n_resolved;
  logic [31:0]          n_mispred;

  modport master (
    input  ext_flush,
    input  q_empty, q_pc_valid, q_op, q_rob_idx, q_pc_in, q_pc_new,
    input  q_br_en, q_pred_pc, q_rd, q_pd,
    output q_dequeue,
    output cdb_req, cdb_rob_idx, cdb_regwrite, cdb_rd, cdb_pd, cdb_data,
    input  cdb_gnt,
    input  rob_head_valid, rob_head_idx,
    output flush, redirect_pc, n_resolved, n_mispred
  );

  modport slave (
    output ext_flush,
    output q_empty, q_pc_valid, q_op, q_rob_idx, q_pc_in, q_pc_new,
    output q_br_en, q_pred_pc, q_rd, q_pd,
    input  q_dequeue,
    input  cdb_req, cdb_rob_idx, cdb_regwrite, cdb_rd, cdb_pd, cdb_data,
    output cdb_gnt,
    output rob_head_valid, rob_head_idx,
    input  flush, redirect_pc, n_resolved, n_mispred
  );
endinterface

// File: rtl/control_resolve_unit.sv
// control_resolve_unit
//   Consumer at the head of the control-op FIFO (br/jal/jalr/auipc).
//   Latches the head op, waits for its resolved target, broadcasts the
//   result on the CDB, then at ROB commit checks the prediction, pops the
//   FIFO and raises flush/redirect_pc on a mispredict. Counts resolved ops
//   and mispredicts.
//   Ports:
//     clk  clock
//     rst  synchronous active-high reset
//     bus  control_resolve_if.master (FIFO head, CDB, ROB head, redirect,
//          perf counters)
module control_resolve_unit #(
  parameter int ROB_IDX_W = 5,
  parameter int PREG_W    = 6,
  parameter int AREG_W    = 5
) (
  input logic               clk,
  input logic               rst,
  control_resolve_if.master bus
);

  localparam logic [1:0] OP_BR    = 2'd0;
  localparam logic [1:0] OP_JAL   = 2'd1;
  localparam logic [1:0] OP_JALR  = 2'd2;
  localparam logic [1:0] OP_AUIPC = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RES = 3'd1,
    S_BCAST    = 3'd2,
    S_WAIT_CMT = 3'd3,
    S_RESOLVE  = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Latched copy of the head op
  logic [1:0]           op_reg;
  logic [ROB_IDX_W-1:0] rob_idx_reg;
  logic [31:0]          pc_in_reg;
  logic [31:0]          pred_pc_reg;
  logic [AREG_W-1:0]    rd_reg;
  logic [PREG_W-1:0]    pd_reg;
  logic [31:0]          pc_new_reg;
  logic                 br_en_reg;

  logic [31:0] n_resolved_reg;
  logic [31:0] n_mispred_reg;

  logic        latch_head;
  logic        latch_res;
  logic        rob_match;
  logic [31:0] pc_plus4;
  logic [31:0] actual_pc;
  logic        mispred;
  logic [31:0] cdb_data_val;
  logic        cdb_req_int;
  logic        dequeue_int;
  logic        flush_int;

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign rob_match = bus.rob_head_valid && (bus.rob_head_idx == rob_idx_reg);

  // ----------------------------------------------------------- next state
  always_comb begin
    state_next = state_reg;
    latch_head = 1'b0;
    latch_res  = 1'b0;
    if (bus.ext_flush) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (!bus.q_empty) begin
            latch_head = 1'b1;
            // Target already resolved at latch time: skip WAIT_RES.
            if (bus.q_pc_valid) begin
              latch_res  = 1'b1;
              state_next = S_BCAST;
            end else begin
              state_next = S_WAIT_RES;
            end
          end
        end
        S_WAIT_RES: begin
          if (bus.q_pc_valid) begin
            latch_res  = 1'b1;
            state_next = S_BCAST;
          end
        end
        S_BCAST: begin
          if (bus.cdb_gnt) begin
            state_next = S_WAIT_CMT;
          end
        end
        S_WAIT_CMT: begin
          if (rob_match) begin
            state_next = S_RESOLVE;
          end
        end
        S_RESOLVE: begin
          // Returning through IDLE gives the FIFO one cycle to present
          // the next head (or to empty itself after a flush).
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------- latches
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg      <= OP_BR;
      rob_idx_reg <= '0;
      pc_in_reg   <= '0;
      pred_pc_reg <= '0;
      rd_reg      <= '0;
      pd_reg      <= '0;
      pc_new_reg  <= '0;
      br_en_reg   <= 1'b0;
    end else begin
      if (latch_head) begin
        op_reg      <= bus.q_op;
        rob_idx_reg <= bus.q_rob_idx;
        pc_in_reg   <= bus.q_pc_in;
        pred_pc_reg <= bus.q_pred_pc;
        rd_reg      <= bus.q_rd;
        pd_reg      <= bus.q_pd;
      end
      if (latch_res) begin
        pc_new_reg <= bus.q_pc_new;
        br_en_reg  <= bus.q_br_en;
      end
    end
  end

  // ---------------------------------------------- resolve datapath (regs)
  assign pc_plus4 = pc_in_reg + 32'd4;

  always_comb begin
    actual_pc    = pc_plus4;
    cdb_data_val = '0;
    case (op_reg)
      OP_BR: begin
        actual_pc    = br_en_reg ? pc_new_reg : pc_plus4;
        cdb_data_val = '0;
      end
      OP_JAL, OP_JALR: begin
        actual_pc    = pc_new_reg;
        cdb_data_val = pc_plus4;
      end
      OP_AUIPC: begin
        // auipc never redirects; pc_new carries its result value.
        actual_pc    = pc_plus4;
        cdb_data_val = pc_new_reg;
      end
      default: begin
        actual_pc    = pc_plus4;
        cdb_data_val = '0;
      end
    endcase
  end

  assign mispred = (actual_pc != pred_pc_reg);

  // -------------------------------------------------------------- outputs
  // Moore decodes of state; ext_flush is the only input that can squash
  // them in the same cycle.
  always_comb begin
    cdb_req_int = 1'b0;
    dequeue_int = 1'b0;
    flush_int   = 1'b0;
    if (!bus.ext_flush) begin
      case (state_reg)
        S_BCAST: begin
          cdb_req_int = 1'b1;
        end
        S_RESOLVE: begin
          dequeue_int = 1'b1;
          flush_int   = mispred;
        end
        default: begin
          cdb_req_int = 1'b0;
        end
      endcase
    end
  end

  assign bus.cdb_req      = cdb_req_int;
  assign bus.q_dequeue    = dequeue_int;
  assign bus.flush        = flush_int;
  assign bus.redirect_pc  = flush_int ? actual_pc : 32'd0;
  // Payload is zero outside a request so idle outputs stay quiet.
  assign bus.cdb_rob_idx  = cdb_req_int ? rob_idx_reg : '0;
  assign bus.cdb_regwrite = cdb_req_int && (op_reg != OP_BR);
  assign bus.cdb_rd       = cdb_req_int ? rd_reg : '0;
  assign bus.cdb_pd       = cdb_req_int ? pd_reg : '0;
  assign bus.cdb_data     = cdb_req_int ? cdb_data_val : 32'd0;

  // ------------------------------------------------------------- counters
  always_ff @(posedge clk) begin
    if (rst) begin
      n_resolved_reg <= '0;
      n_mispred_reg  <= '0;
    end else if (state_reg == S_RESOLVE && !bus.ext_flush) begin
      n_resolved_reg <= n_resolved_reg + 32'd1;
      if (mispred) begin
        n_mispred_reg <= n_mispred_reg + 32'd1;
      end
    end
  end

  assign bus.n_resolved = n_resolved_reg;
  assign bus.n_mispred  = n_mispred_reg;

endmodule

// File: tb/tb_control_resolve_unit.sv
module tb_control_resolve_unit;
  localparam int ROB_IDX_W = 5;
  localparam int PREG_W    = 6;
  localparam int AREG_W    = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_resolve_if #(.ROB_IDX_W(ROB_IDX_W), .PREG_W(PREG_W), .AREG_W(AREG_W)) bus();

  control_resolve_unit #(.ROB_IDX_W(ROB_IDX_W), .PREG_W(PREG_W), .AREG_W(AREG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]           op;
    logic [31:0]          pc_in;
    logic [31:0]          pc_new;
    logic                 br_en;
    logic [31:0]          pred;
    logic [ROB_IDX_W-1:0] rob;
    logic [AREG_W-1:0]    rd;
    logic [PREG_W-1:0]    pd;
    int                   vdly;   // cycles before q_pc_valid
    int                   gdly;   // request cycles refused before grant
    int                   cdly;   // WAIT_CMT cycles with ROB head mismatched
    logic [31:0]          exp_data;
    logic                 exp_rw;
    logic                 exp_flush;
    logic [31:0]          exp_redir;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int m_resolved = 0;
  int m_mispred  = 0;
  int cyc_abs = 0;
  int last_deq_abs = -1;
  vec_t dir_tab[7];

  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: what the op really does, straight from the op definitions.
  function automatic logic [31:0] ref_next_pc(vec_t v);
    case (v.op)
      2'd0:    return v.br_en ? v.pc_new : v.pc_in + 32'd4;
      2'd1:    return v.pc_new;
      2'd2:    return v.pc_new;
      default: return v.pc_in + 32'd4;
    endcase
  endfunction

  function automatic logic [31:0] ref_data(vec_t v);
    case (v.op)
      2'd0:    return 32'd0;
      2'd3:    return v.pc_new;
      default: return v.pc_in + 32'd4;
    endcase
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.op     = 2'($urandom_range(0, 3));
    v.pc_in  = $urandom() & 32'hFFFF_FFFC;
    v.pc_new = $urandom() & 32'hFFFF_FFFC;
    v.br_en  = 1'($urandom_range(0, 1));
    v.rob    = ROB_IDX_W'($urandom_range(0, 31));
    v.rd     = AREG_W'($urandom_range(0, 31));
    v.pd     = PREG_W'($urandom_range(0, 63));
    v.vdly   = $urandom_range(0, 4);
    v.gdly   = $urandom_range(0, 4);
    v.cdly   = $urandom_range(0, 4);
    v.pred   = ($urandom_range(0, 1) == 1) ? ref_next_pc(v) : ($urandom() & 32'hFFFF_FFFC);
    v.exp_data  = ref_data(v);
    v.exp_rw    = (v.op != 2'd0);
    v.exp_redir = ref_next_pc(v);
    v.exp_flush = (v.exp_redir != v.pred);
    return v;
  endfunction

  task automatic drive_head(input vec_t v);
    bus.q_empty   = 1'b0;
    bus.q_op      = v.op;
    bus.q_rob_idx = v.rob;
    bus.q_pc_in   = v.pc_in;
    bus.q_pc_new  = v.pc_new;
    bus.q_br_en   = v.br_en;
    bus.q_pred_pc = v.pred;
    bus.q_rd      = v.rd;
    bus.q_pd      = v.pd;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.q_empty        = 1'b1;
      bus.q_pc_valid     = 1'($urandom_range(0, 1));
      bus.rob_head_valid = 1'($urandom_range(0, 1));
      bus.rob_head_idx   = ROB_IDX_W'($urandom_range(0, 31));
      #1;
      chk("idle.q_dequeue", 32'(bus.q_dequeue), 32'd0);
      chk("idle.cdb_req", 32'(bus.cdb_req), 32'd0);
      @(negedge clk);
    end
  endtask

  // One op through the unit; starts at a negedge with the unit in IDLE.
  task automatic run_op(input vec_t v, input string tag);
    int req_cycles = 0, grant_cyc = -1, deq_cyc = -1, first_req = -1;
    int deq_cnt = 0, flush_cnt = 0, deq_abs = -1;
    logic stable = 1'b1;
    logic [31:0] s_redir = 32'd0;
    logic [ROB_IDX_W+AREG_W+PREG_W+32:0] snap = '0, cur;
    drive_head(v);
    for (int c = 0; c < 200; c++) begin
      bus.q_pc_valid = (c >= v.vdly);
      // Garbage target until it is declared valid.
      bus.q_pc_new = (c >= v.vdly) ? v.pc_new : ~v.pc_new;
      bus.q_br_en  = (c >= v.vdly) ? v.br_en : ~v.br_en;
      bus.cdb_gnt  = 1'b0;
      if (grant_cyc >= 0 && c > grant_cyc + v.cdly) begin
        bus.rob_head_valid = 1'b1;
        bus.rob_head_idx   = v.rob;
      end else begin
        bus.rob_head_valid = 1'($urandom_range(0, 1));
        bus.rob_head_idx   = v.rob ^ ROB_IDX_W'(1);
      end
      #1;
      cur = {bus.cdb_rob_idx, bus.cdb_regwrite, bus.cdb_rd, bus.cdb_pd, bus.cdb_data};
      if (bus.cdb_req) begin
        if (first_req < 0) begin
          first_req = c;
          snap = cur;
        end else if (cur !== snap) begin
          stable = 1'b0;
        end
        req_cycles++;
        if (req_cycles > v.gdly) begin
          bus.cdb_gnt = 1'b1;
          grant_cyc = c;
        end
      end
      if (bus.flush) begin
        flush_cnt++;
        s_redir = bus.redirect_pc;
      end
      if (bus.q_dequeue) begin
        deq_cnt++;
        deq_cyc = c;
        deq_abs = cyc_abs;
      end
      @(negedge clk);
      if (deq_cyc >= 0) break;
    end
    bus.q_empty = 1'b1;
    bus.q_pc_valid = 1'b0;
    bus.cdb_gnt = 1'b0;
    bus.rob_head_valid = 1'b0;

    m_resolved++;
    if (v.exp_flush) m_mispred++;
    chk({tag, ".deq_count"}, 32'(deq_cnt), 32'd1);
    chk({tag, ".first_req_cycle"}, 32'(first_req), 32'(v.vdly + 1));
    chk({tag, ".req_cycles"}, 32'(req_cycles), 32'(v.gdly + 1));
    chk({tag, ".cdb_stable"}, 32'(stable), 32'd1);
    chk({tag, ".cdb_data"}, snap[31:0], v.exp_data);
    chk({tag, ".cdb_regwrite"}, 32'(snap[32+PREG_W+AREG_W]), 32'(v.exp_rw));
    chk({tag, ".cdb_dest"}, 32'(snap[32+PREG_W+AREG_W-1:32]), 32'({v.rd, v.pd}));
    chk({tag, ".cdb_rob_idx"}, 32'(snap[ROB_IDX_W+AREG_W+PREG_W+32:33+PREG_W+AREG_W]), 32'(v.rob));
    chk({tag, ".deq_cycle"}, 32'(deq_cyc), 32'(grant_cyc + v.cdly + 2));
    chk({tag, ".flush_count"}, 32'(flush_cnt), 32'(v.exp_flush));
    if (v.exp_flush) chk({tag, ".redirect_pc"}, s_redir, v.exp_redir);
    if (last_deq_abs >= 0 && deq_abs >= 0)
      chk({tag, ".deq_spacing_ok"}, 32'(deq_abs - last_deq_abs >= 2), 32'd1);
    if (deq_abs >= 0) last_deq_abs = deq_abs;
    #1;
    chk({tag, ".n_resolved"}, bus.n_resolved, 32'(m_resolved));
    chk({tag, ".n_mispred"}, bus.n_mispred, 32'(m_mispred));
    $display("op %s: op=%0d pc_in=%08h data=%08h flush=%0d redirect=%08h n_res=%0d n_mis=%0d",
             tag, v.op, v.pc_in, snap[31:0], flush_cnt, s_redir, bus.n_resolved, bus.n_mispred);
  endtask

  initial begin
    vec_t v;
    //               op     pc_in         pc_new        br    pred          rob    rd     pd     vd gd cd  exp_data      rw    fl    redir
    dir_tab[0] = '{2'd1, 32'h0000_0100, 32'h0000_0200, 1'b0, 32'h0000_0200, 5'd3,  5'd1,  6'd10, 0, 0, 0, 32'h0000_0104, 1'b1, 1'b0, 32'h0000_0200};
    dir_tab[1] = '{2'd0, 32'h0000_0040, 32'h0000_0080, 1'b1, 32'h0000_0044, 5'd4,  5'd0,  6'd0,  0, 0, 0, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0080};
    dir_tab[2] = '{2'd0, 32'h0000_0040, 32'h0000_0080, 1'b0, 32'h0000_0044, 5'd5,  5'd0,  6'd0,  5, 3, 0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0044};
    dir_tab[3] = '{2'd3, 32'h0000_1000, 32'h1234_5000, 1'b0, 32'h0000_1004, 5'd6,  5'd7,  6'd33, 0, 0, 4, 32'h1234_5000, 1'b1, 1'b0, 32'h0000_1004};
    dir_tab[4] = '{2'd2, 32'h0000_2000, 32'h0000_3000, 1'b0, 32'h0000_2004, 5'd7,  5'd2,  6'd12, 1, 1, 1, 32'h0000_2004, 1'b1, 1'b1, 32'h0000_3000};
    dir_tab[5] = '{2'd1, 32'hFFFF_FFFC, 32'h0000_0010, 1'b0, 32'h0000_0010, 5'd31, 5'd31, 6'd63, 0, 0, 0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0010};
    dir_tab[6] = '{2'd3, 32'hFFFF_FFFC, 32'h0000_0ABC, 1'b0, 32'h0000_0000, 5'd0,  5'd9,  6'd1,  2, 0, 0, 32'h0000_0ABC, 1'b1, 1'b0, 32'h0000_0000};

    rst = 1'b1;
    bus.ext_flush = 1'b0; bus.q_empty = 1'b1; bus.q_pc_valid = 1'b0;
    bus.q_op = 2'd0; bus.q_rob_idx = '0; bus.q_pc_in = '0; bus.q_pc_new = '0;
    bus.q_br_en = 1'b0; bus.q_pred_pc = '0; bus.q_rd = '0; bus.q_pd = '0;
    bus.cdb_gnt = 1'b0; bus.rob_head_valid = 1'b0; bus.rob_head_idx = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset.q_dequeue", 32'(bus.q_dequeue), 32'd0);
    chk("reset.cdb_req", 32'(bus.cdb_req), 32'd0);
    chk("reset.flush", 32'(bus.flush), 32'd0);
    chk("reset.n_resolved", bus.n_resolved, 32'd0);
    chk("reset.n_mispred", bus.n_mispred, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2);

    // Directed table (dir 0..2 also run back-to-back with no gap).
    for (int i = 0; i < 7; i++) run_op(dir_tab[i], $sformatf("dir%0d", i));

    // ext_flush while broadcasting: request squashed, grant ignored.
    drive_head(dir_tab[0]);
    bus.q_pc_valid = 1'b1;
    @(negedge clk);
    #1 chk("xf_bcast.pre_req", 32'(bus.cdb_req), 32'd1);
    bus.ext_flush = 1'b1; bus.cdb_gnt = 1'b1;
    #1 chk("xf_bcast.cdb_req", 32'(bus.cdb_req), 32'd0);
    @(negedge clk);
    bus.ext_flush = 1'b0; bus.cdb_gnt = 1'b0; bus.q_pc_valid = 1'b0;
    idle_cycles(3);
    chk("xf_bcast.n_resolved", bus.n_resolved, 32'(m_resolved));
    $display("seq ext_flush in BCAST done");
    run_op(dir_tab[2], "after_xf_bcast");

    // ext_flush in the RESOLVE cycle of a mispredicting branch.
    drive_head(dir_tab[1]);
    bus.q_pc_valid = 1'b1;
    @(negedge clk);
    bus.cdb_gnt = 1'b1;
    #1 chk("xf_res.req", 32'(bus.cdb_req), 32'd1);
    @(negedge clk);
    bus.cdb_gnt = 1'b0; bus.rob_head_valid = 1'b1; bus.rob_head_idx = dir_tab[1].rob;
    @(negedge clk);
    bus.ext_flush = 1'b1;
    #1;
    chk("xf_res.q_dequeue", 32'(bus.q_dequeue), 32'd0);
    chk("xf_res.flush", 32'(bus.flush), 32'd0);
    @(negedge clk);
    bus.ext_flush = 1'b0; bus.q_pc_valid = 1'b0;
    idle_cycles(2);
    chk("xf_res.n_resolved", bus.n_resolved, 32'(m_resolved));
    chk("xf_res.n_mispred", bus.n_mispred, 32'(m_mispred));
    $display("seq ext_flush in RESOLVE done");
    run_op(dir_tab[4], "after_xf_res");

    // Reset while waiting for commit.
    drive_head(dir_tab[3]);
    bus.q_pc_valid = 1'b1;
    @(negedge clk);
    bus.cdb_gnt = 1'b1;
    @(negedge clk);
    bus.cdb_gnt = 1'b0; bus.rob_head_valid = 1'b1; bus.rob_head_idx = dir_tab[3].rob ^ ROB_IDX_W'(1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.q_empty = 1'b1; bus.q_pc_valid = 1'b0; bus.rob_head_valid = 1'b0;
    #1;
    chk("rst_mid.q_dequeue", 32'(bus.q_dequeue), 32'd0);
    chk("rst_mid.cdb_req", 32'(bus.cdb_req), 32'd0);
    chk("rst_mid.flush", 32'(bus.flush), 32'd0);
    chk("rst_mid.redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst_mid.cdb_data", bus.cdb_data, 32'd0);
    chk("rst_mid.n_resolved", bus.n_resolved, 32'd0);
    chk("rst_mid.n_mispred", bus.n_mispred, 32'd0);
    m_resolved = 0; m_mispred = 0; last_deq_abs = -1;
    $display("seq reset mid WAIT_CMT done");
    @(negedge clk);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      v = rand_vec();
      run_op(v, $sformatf("rnd%0d", i));
      idle_cycles($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
